// File: rtl/latency_checker_pkg.sv
// Shared types and helpers for the latency/data checker.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package latency_checker_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISSING,
    ERR_MISMATCH,
    ERR_SPURIOUS
  } err_kind_e;

  // a + b clamped to the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/latchk_delay_line.sv
// Per-channel token delay line: a token pushed at edge t appears on the tap until edge t+lat.
// Latency: lat cycles (1..MAX_LAT) from push to the check edge; tokens retire at the tap.
// Backpressure: none, accepts one push per cycle.
// Ports: clk/rst, push+din (new token), lat (tap position), tap_vld/tap_data, occupied.
module latchk_delay_line
  import latency_checker_pkg::*;
#(
  parameter int W       = 64,
  parameter int MAX_LAT = 8,
  parameter int LW      = $clog2(MAX_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic [LW-1:0] lat,
  output logic          tap_vld,
  output logic [W-1:0]  tap_data,
  output logic          occupied
);

  logic [MAX_LAT-1:0] vld_q, vld_d;
  logic [W-1:0]       dat_q [MAX_LAT];

  // Stage k holds the token launched k+1 edges ago. Validity is not carried
  // past stage lat-1, so a token retires as soon as it has been checked and
  // busy drops right after the last check.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = push;
    for (int k = 1; k < MAX_LAT; k++) begin
      vld_d[k] = vld_q[k-1] && (LW'(k) < lat);
    end
  end

  always_comb begin
    tap_vld  = 1'b0;
    tap_data = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (LW'(k + 1) == lat) begin
        tap_vld  = vld_q[k];
        tap_data = dat_q[k];
      end
    end
  end

  assign occupied = |vld_q;

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // Data needs no reset: it is only looked at alongside a valid bit.
  always_ff @(posedge clk) begin
    dat_q[0] <= din;
    for (int k = 1; k < MAX_LAT; k++) dat_q[k] <= dat_q[k-1];
  end

endmodule

// File: rtl/latency_checker.sv
// Checks that each launched token returns on its channel exactly lat_q cycles later with equal data.
// Latency: all status outputs registered, updated at the check edge; busy follows pipeline state.
// Backpressure: none; full-rate arg_vld supported, results are never stalled.
// Ports: clk/rst/en/clr, lat_cfg, arg_vld/arg_data, res_vld/res_data in;
//        busy, cfg_err, err, err_cnt, ok_cnt, fe_vld/fe_ch/fe_kind/fe_exp/fe_got out.
module latency_checker
  import latency_checker_pkg::*;
#(
  parameter int W       = 64,
  parameter int N_CH    = 2,
  parameter int MAX_LAT = 8,
  parameter int CNT_W   = 16,
  localparam int LW     = $clog2(MAX_LAT + 1),
  localparam int FE_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [N_CH*LW-1:0] lat_cfg,
  input  logic              arg_vld,
  input  logic [N_CH*W-1:0] arg_data,
  input  logic [N_CH-1:0]   res_vld,
  input  logic [N_CH*W-1:0] res_data,
  output logic              busy,
  output logic [N_CH-1:0]   cfg_err,
  output logic [N_CH-1:0]   err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic              fe_vld,
  output logic [FE_W-1:0]   fe_ch,
  output err_kind_e         fe_kind,
  output logic [W-1:0]      fe_exp,
  output logic [W-1:0]      fe_got
);

  localparam int CW = $clog2(N_CH + 1);

  logic [N_CH*LW-1:0] lat_q, lat_d;
  logic [N_CH-1:0]    cfg_err_q, cfg_err_d;
  logic [N_CH-1:0]    err_q, err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d, ok_cnt_q, ok_cnt_d;
  logic               fe_vld_q, fe_vld_d;
  logic [FE_W-1:0]    fe_ch_q, fe_ch_d;
  err_kind_e          fe_kind_q, fe_kind_d;
  logic [W-1:0]       fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;

  logic [N_CH-1:0]    tap_vld, occ;
  logic [N_CH*W-1:0]  tap_data;
  logic [CW-1:0]      ok_inc, err_inc;
  logic               tok, rv;
  logic [W-1:0]       exp_w, got_w;
  err_kind_e          kind;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    latchk_delay_line #(.W(W), .MAX_LAT(MAX_LAT), .LW(LW)) u_dl (
      .clk      (clk),
      .rst      (rst),
      .push     (en & arg_vld & ~cfg_err_q[ch]),
      .din      (arg_data[ch*W +: W]),
      .lat      (lat_q[ch*LW +: LW]),
      .tap_vld  (tap_vld[ch]),
      .tap_data (tap_data[ch*W +: W]),
      .occupied (occ[ch])
    );
  end

  assign busy = |occ;

  always_comb begin
    lat_d     = lat_q;
    cfg_err_d = cfg_err_q;
    err_d     = err_q;
    fe_vld_d  = fe_vld_q;
    fe_ch_d   = fe_ch_q;
    fe_kind_d = fe_kind_q;
    fe_exp_d  = fe_exp_q;
    fe_got_d  = fe_got_q;
    ok_inc    = '0;
    err_inc   = '0;
    tok       = 1'b0;
    rv        = 1'b0;
    exp_w     = '0;
    got_w     = '0;
    kind      = ERR_NONE;

    for (int ch = 0; ch < N_CH; ch++) begin
      // A disabled channel neither launches nor reports, so mask both sides.
      tok   = tap_vld[ch] & ~cfg_err_q[ch];
      rv    = res_vld[ch] & ~cfg_err_q[ch];
      exp_w = tok ? tap_data[ch*W +: W] : '0;
      got_w = rv ? res_data[ch*W +: W] : '0;
      kind  = ERR_NONE;
      if (tok && rv) begin
        if (exp_w == got_w) ok_inc = ok_inc + CW'(1);
        else                kind   = ERR_MISMATCH;
      end else if (tok) begin
        kind = ERR_MISSING;
      end else if (rv) begin
        kind = ERR_SPURIOUS;
      end

      if (kind != ERR_NONE) begin
        err_inc    = err_inc + CW'(1);
        err_d[ch]  = 1'b1;
        // Ascending scan: once set here, higher channels cannot overwrite.
        if (!fe_vld_d) begin
          fe_vld_d  = 1'b1;
          fe_ch_d   = FE_W'(ch);
          fe_kind_d = kind;
          fe_exp_d  = exp_w;
          fe_got_d  = got_w;
        end
      end

      // Latency only changes with the pipeline empty, so no token can be
      // checked at a tap it was not launched for.
      if (!en && !busy) begin
        if (lat_cfg[ch*LW +: LW] == '0 || lat_cfg[ch*LW +: LW] > LW'(MAX_LAT)) begin
          cfg_err_d[ch]         = 1'b1;
          lat_d[ch*LW +: LW]    = LW'(1);
        end else begin
          cfg_err_d[ch]         = 1'b0;
          lat_d[ch*LW +: LW]    = lat_cfg[ch*LW +: LW];
        end
      end
    end

    err_cnt_d = CNT_W'(sat_add(64'(err_cnt_q), 64'(err_inc), CNT_W));
    ok_cnt_d  = CNT_W'(sat_add(64'(ok_cnt_q), 64'(ok_inc), CNT_W));

    if (clr) begin
      err_d     = '0;
      err_cnt_d = '0;
      ok_cnt_d  = '0;
      fe_vld_d  = 1'b0;
      fe_ch_d   = '0;
      fe_kind_d = ERR_NONE;
      fe_exp_d  = '0;
      fe_got_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q     <= {N_CH{LW'(1)}};
      cfg_err_q <= '0;
      err_q     <= '0;
      err_cnt_q <= '0;
      ok_cnt_q  <= '0;
      fe_vld_q  <= 1'b0;
      fe_ch_q   <= '0;
      fe_kind_q <= ERR_NONE;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
    end else begin
      lat_q     <= lat_d;
      cfg_err_q <= cfg_err_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      ok_cnt_q  <= ok_cnt_d;
      fe_vld_q  <= fe_vld_d;
      fe_ch_q   <= fe_ch_d;
      fe_kind_q <= fe_kind_d;
      fe_exp_q  <= fe_exp_d;
      fe_got_q  <= fe_got_d;
    end
  end

  assign cfg_err = cfg_err_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign ok_cnt  = ok_cnt_q;
  assign fe_vld  = fe_vld_q;
  assign fe_ch   = fe_ch_q;
  assign fe_kind = fe_kind_q;
  assign fe_exp  = fe_exp_q;
  assign fe_got  = fe_got_q;

endmodule

// File: tb/tb_latency_checker.sv
// Bench for latency_checker: directed scenarios plus random traffic against a scoreboard model.
// Latency: model keyed by absolute due cycle; outputs compared every negedge.
// Backpressure: n/a.
module tb_latency_checker;
  import latency_checker_pkg::*;

  localparam int W = 64, N_CH = 2, MAX_LAT = 8, CNT_W = 8, LW = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BC = 64'hBCBC_BCBC_BCBC_BCBC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, clr, arg_vld;
  logic [N_CH*LW-1:0] lat_cfg;
  logic [N_CH*W-1:0]  arg_data, res_data;
  logic [N_CH-1:0]    res_vld;
  logic               busy, fe_vld;
  logic [N_CH-1:0]    cfg_err, err;
  logic [CNT_W-1:0]   err_cnt, ok_cnt;
  logic [0:0]         fe_ch;
  err_kind_e          fe_kind;
  logic [W-1:0]       fe_exp, fe_got;

  latency_checker #(.W(W), .N_CH(N_CH), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .lat_cfg(lat_cfg),
    .arg_vld(arg_vld), .arg_data(arg_data), .res_vld(res_vld), .res_data(res_data),
    .busy(busy), .cfg_err(cfg_err), .err(err), .err_cnt(err_cnt), .ok_cnt(ok_cnt),
    .fe_vld(fe_vld), .fe_ch(fe_ch), .fe_kind(fe_kind), .fe_exp(fe_exp), .fe_got(fe_got)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Scoreboard of expected tokens keyed by (due edge index * 2 + channel).
  logic [63:0] sb [int];
  int          cyc = 0;       // index of the next rising edge
  int          max_due = -1;  // latest due edge of any launched token
  bit          started = 0;
  int          m_lat [N_CH];
  bit [1:0]    m_cfg_err, m_err;
  int          m_err_cnt, m_ok_cnt, m_fe_ch, m_errn, m_okn, m_key, m_due;
  bit          m_fe_vld, m_pre_busy, m_t, m_r;
  err_kind_e   m_fe_kind, m_kind;
  logic [63:0] m_fe_exp, m_fe_got, m_e, m_g;
  logic [3:0]  m_v;

  task automatic model_clear_status();
    m_err = '0; m_err_cnt = 0; m_ok_cnt = 0;
    m_fe_vld = 0; m_fe_ch = 0; m_fe_kind = ERR_NONE; m_fe_exp = '0; m_fe_got = '0;
  endtask

  initial forever begin
    @(posedge clk);
    started = 1;
    if (rst) begin
      sb.delete();
      max_due = -1;
      for (int ch = 0; ch < N_CH; ch++) m_lat[ch] = 1;
      m_cfg_err = '0;
      model_clear_status();
    end else begin
      m_pre_busy = (max_due >= cyc);
      m_errn = 0; m_okn = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (!m_cfg_err[ch]) begin
          m_key = cyc * 2 + ch;
          m_t = sb.exists(m_key) != 0;
          m_r = res_vld[ch];
          m_e = m_t ? sb[m_key] : 64'd0;
          m_g = m_r ? res_data[ch*W +: W] : 64'd0;
          if (m_t) sb.delete(m_key);
          m_kind = ERR_NONE;
          if (m_t && m_r && m_e == m_g) m_okn++;
          else if (m_t && m_r) m_kind = ERR_MISMATCH;
          else if (m_t)        m_kind = ERR_MISSING;
          else if (m_r)        m_kind = ERR_SPURIOUS;
          if (m_kind != ERR_NONE) begin
            m_errn++;
            m_err[ch] = 1'b1;
            if (!m_fe_vld) begin
              m_fe_vld = 1; m_fe_ch = ch; m_fe_kind = m_kind; m_fe_exp = m_e; m_fe_got = m_g;
            end
          end
        end
      end
      if (en && arg_vld) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (!m_cfg_err[ch]) begin
            m_due = cyc + m_lat[ch];
            sb[m_due * 2 + ch] = arg_data[ch*W +: W];
            if (m_due > max_due) max_due = m_due;
          end
        end
      end
      if (!en && !m_pre_busy) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          m_v = lat_cfg[ch*LW +: LW];
          if (m_v == 0 || m_v > MAX_LAT) begin m_cfg_err[ch] = 1; m_lat[ch] = 1; end
          else begin m_cfg_err[ch] = 0; m_lat[ch] = int'(m_v); end
        end
      end
      m_err_cnt = (m_err_cnt + m_errn > CNT_MAX) ? CNT_MAX : m_err_cnt + m_errn;
      m_ok_cnt  = (m_ok_cnt + m_okn > CNT_MAX) ? CNT_MAX : m_ok_cnt + m_okn;
      if (clr) model_clear_status();
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("busy",    64'(busy),    64'(max_due >= cyc));
      chk("cfg_err", 64'(cfg_err), 64'(m_cfg_err));
      chk("err",     64'(err),     64'(m_err));
      chk("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
      chk("ok_cnt",  64'(ok_cnt),  64'(m_ok_cnt));
      chk("fe_vld",  64'(fe_vld),  64'(m_fe_vld));
      chk("fe_ch",   64'(fe_ch),   64'(m_fe_ch));
      chk("fe_kind", 64'(fe_kind), 64'(m_fe_kind));
      chk("fe_exp",  fe_exp,       m_fe_exp);
      chk("fe_got",  fe_got,       m_fe_got);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_clr();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
  endtask

  // One launch, then results on ch0/ch1 presented k0/k1 cycles later.
  task automatic single(input logic [63:0] d0, d1, g0, g1, input int k0, k1);
    en = 1'b1; arg_vld = 1'b1; arg_data = {d1, d0};
    @(negedge clk);
    arg_vld = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      res_vld  = {k == k1, k == k0};
      res_data = {g1, g0};
      @(negedge clk);
    end
    res_vld = '0;
  endtask

  function automatic logic [3:0] rnd_lat();
    int v;
    if ($urandom_range(0, 4) == 0) begin
      v = $urandom_range(8, 15);
      return (v == 8) ? 4'd0 : 4'(v);
    end
    return 4'($urandom_range(1, 8));
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; arg_vld = 1'b0;
    lat_cfg = {4'd5, 4'd3}; arg_data = '0; res_vld = '0; res_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fe_kind", 64'(fe_kind), 64'(ERR_NONE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // correct results at +3/+5
    do_clr();
    single(AA, BB, AA, BB, 3, 5);
    chk("s1_ok_cnt", 64'(ok_cnt), 64'd2);
    chk("s1_err", 64'(err), 64'd0);
    chk("s1_busy", 64'(busy), 64'd0);

    // ch1 mismatch
    do_clr();
    single(AA, BB, AA, BC, 3, 5);
    chk("s2_err", 64'(err), 64'b10);
    chk("s2_err_cnt", 64'(err_cnt), 64'd1);
    chk("s2_fe_kind", 64'(fe_kind), 64'(ERR_MISMATCH));
    chk("s2_fe_ch", 64'(fe_ch), 64'd1);
    chk("s2_fe_exp", fe_exp, BB);
    chk("s2_fe_got", fe_got, BC);

    // ch0 one cycle late: missing then spurious
    do_clr();
    single(AA, BB, AA, BB, 4, 5);
    chk("s3_err_cnt", 64'(err_cnt), 64'd2);
    chk("s3_fe_kind", 64'(fe_kind), 64'(ERR_MISSING));
    chk("s3_fe_ch", 64'(fe_ch), 64'd0);
    chk("s3_ok_cnt", 64'(ok_cnt), 64'd1);

    // 20 back-to-back launches
    do_clr();
    for (int k = 0; k < 26; k++) begin
      en = 1'b1;
      arg_vld  = (k < 20);
      arg_data = {64'(k + 1000), 64'(k)};
      res_vld  = {(k >= 5 && k < 25), (k >= 3 && k < 23)};
      res_data = {64'(k - 5 + 1000), 64'(k - 3)};
      @(negedge clk);
    end
    res_vld = '0; arg_vld = 1'b0;
    chk("s4_ok_cnt", 64'(ok_cnt), 64'd40);
    chk("s4_err_cnt", 64'(err_cnt), 64'd0);

    // error counter saturation
    do_clr();
    res_vld = 2'b11;
    repeat (128) @(negedge clk);
    chk("sat_err_cnt", 64'(err_cnt), 64'(CNT_MAX));
    res_vld = 2'b01;
    @(negedge clk);
    res_vld = '0;
    chk("sat_hold", 64'(err_cnt), 64'(CNT_MAX));

    // ch0 latency 0 disables it
    en = 1'b0; lat_cfg = {4'd5, 4'd0};
    repeat (2) @(negedge clk);
    chk("cfg_err01", 64'(cfg_err), 64'b01);
    do_clr();
    single(AA, BB, 64'h11, BB, 3, 5);
    chk("s5_err", 64'(err), 64'd0);
    chk("s5_ok_cnt", 64'(ok_cnt), 64'd1);

    // latency change while busy is ignored until drained
    en = 1'b1; arg_vld = 1'b1; arg_data = {BB, AA};
    @(negedge clk);
    en = 1'b0; arg_vld = 1'b0; lat_cfg = {4'd2, 4'd3};
    for (int k = 1; k <= 7; k++) begin
      res_vld = {k == 5, 1'b0}; res_data = {BB, AA};
      @(negedge clk);
    end
    res_vld = '0;
    chk("s5_busy_lat", 64'(ok_cnt), 64'd2);
    chk("s5_err2", 64'(err), 64'd0);
    chk("s5_cfg_relatch", 64'(cfg_err), 64'd0);
    lat_cfg = {4'd5, 4'd3};
    repeat (2) @(negedge clk);

    // reset with tokens in flight
    do_clr();
    en = 1'b1; arg_vld = 1'b1;
    repeat (3) @(negedge clk);
    arg_vld = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_flush_busy", 64'(busy), 64'd0);
    chk("rst_flush_errcnt", 64'(err_cnt), 64'd0);
    chk("rst_flush_fe", 64'(fe_vld), 64'd0);
    rst = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_no_late_err", 64'(err_cnt), 64'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 29) == 0) en = ~en;
      if (!en && $urandom_range(0, 3) == 0) lat_cfg = {rnd_lat(), rnd_lat()};
      arg_vld  = 1'($urandom_range(0, 1));
      arg_data = {$urandom, $urandom, $urandom, $urandom};
      for (int ch = 0; ch < N_CH; ch++) begin
        int p;
        logic [63:0] d;
        p = $urandom_range(0, 19);
        if (sb.exists(cyc * 2 + ch) != 0) begin
          d = sb[cyc * 2 + ch];
          if (p >= 16) d = d ^ (64'd1 << $urandom_range(0, 63));
          res_vld[ch] = (p < 18);
        end else begin
          d = {$urandom, $urandom};
          res_vld[ch] = (p == 0);
        end
        res_data[ch*W +: W] = d;
      end
      @(negedge clk);
    end
    rst = 1'b0; clr = 1'b0; arg_vld = 1'b0; res_vld = '0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
